// File: rtl/warp_scheduler.sv
// Warp scheduler: launches a block of warps and sequences one in-flight warp at a time through
// FETCH..UPDATE, round-robining over the warps that are still ready.
// warp_state_o slot encodings: 0 IDLE, 1 FETCH, 2 DECODE, 3 REQUEST, 4 WAIT, 5 EXECUTE,
// 6 UPDATE, 7 DONE.
module warp_scheduler #(
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned WARP_IDX_W = $clog2(NUM_WARPS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [WARP_IDX_W:0]           num_warps_i,
  output logic                          fetch_req_o,
  input  logic                          fetch_ack_i,
  input  logic                          decoded_mem_i,
  input  logic                          decoded_ret_i,
  output logic                          lsu_req_o,
  input  logic                          lsu_done_i,
  output logic [WARP_IDX_W-1:0]         active_warp_o,
  output logic [NUM_WARPS-1:0][2:0]     warp_state_o,
  output logic [NUM_WARPS-1:0]          warp_enable_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned CntW = WARP_IDX_W + 1;
  localparam logic [2:0] WarpIdle = 3'd0;
  localparam logic [2:0] WarpDone = 3'd7;

  // Phase values double as the warp_state encoding of the in-flight warp.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StRequest = 3'd3,
    StWait    = 3'd4,
    StExecute = 3'd5,
    StUpdate  = 3'd6
  } phase_e;

  phase_e                  phase_q, phase_d;
  logic [WARP_IDX_W-1:0]   active_q, active_d;
  logic [NUM_WARPS-1:0]    ready_q, ready_d;
  logic [NUM_WARPS-1:0]    finished_q, finished_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mem_q, mem_d;
  logic                    ret_q, ret_d;

  logic [WARP_IDX_W:0]     n_launch;
  logic [NUM_WARPS-1:0]    launch_mask;
  logic [NUM_WARPS-1:0]    active_oh;
  logic [NUM_WARPS-1:0]    cand;
  logic                    found;
  logic [WARP_IDX_W-1:0]   next_idx;
  logic [WARP_IDX_W-1:0]   probe;
  logic                    launch;

  assign n_launch  = (num_warps_i > CntW'(NUM_WARPS)) ? CntW'(NUM_WARPS) : num_warps_i;
  assign active_oh = NUM_WARPS'(1) << active_q;
  assign launch    = start_i && !busy_q;

  // Launch mask, next-warp candidates and cyclic search starting after the current warp.
  always_comb begin
    launch_mask = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      launch_mask[i] = (CntW'(i) < n_launch);
    end
    cand = ready_q;
    if (!ret_q) begin
      cand = cand | active_oh;
    end
    found    = 1'b0;
    next_idx = '0;
    probe    = '0;
    // i == NUM_WARPS wraps back to the current warp, so it is considered last.
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      probe = active_q + WARP_IDX_W'(i);
      if (!found && cand[probe]) begin
        found    = 1'b1;
        next_idx = probe;
      end
    end
  end

  // Next-state logic: launch handling and the per-instruction FSM of the active warp.
  always_comb begin
    phase_d    = phase_q;
    active_d   = active_q;
    ready_d    = ready_q;
    finished_d = finished_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_d      = mem_q;
    ret_d      = ret_q;
    if (launch) begin
      finished_d = '0;
      mem_d      = 1'b0;
      ret_d      = 1'b0;
      active_d   = '0;
      if (n_launch == '0) begin
        done_d  = 1'b1;
        ready_d = '0;
      end else begin
        // Warp 0 is issued straight away; the rest wait in the ready set.
        busy_d  = 1'b1;
        phase_d = StFetch;
        ready_d = launch_mask & ~NUM_WARPS'(1);
      end
    end else if (busy_q) begin
      unique case (phase_q)
        StFetch: begin
          if (fetch_ack_i) phase_d = StDecode;
        end
        StDecode: begin
          mem_d   = decoded_mem_i;
          ret_d   = decoded_ret_i;
          phase_d = StRequest;
        end
        StRequest: phase_d = StWait;
        StWait: begin
          if (!mem_q || lsu_done_i) phase_d = StExecute;
        end
        StExecute: phase_d = StUpdate;
        StUpdate: begin
          if (ret_q) begin
            finished_d[active_q] = 1'b1;
          end
          if (found) begin
            active_d = next_idx;
            ready_d  = cand & ~(NUM_WARPS'(1) << next_idx);
            phase_d  = StFetch;
          end else begin
            ready_d = '0;
            phase_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: phase_d = StIdle;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q    <= StIdle;
      active_q   <= '0;
      ready_q    <= '0;
      finished_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= 1'b0;
      ret_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      active_q   <= active_d;
      ready_q    <= ready_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
      ret_q      <= ret_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (phase_q != StIdle && active_q == WARP_IDX_W'(w)) begin
        warp_state_o[w] = phase_q;
      end else if (finished_q[w]) begin
        warp_state_o[w] = WarpDone;
      end else begin
        warp_state_o[w] = WarpIdle;
      end
    end
    warp_enable_o = (phase_q != StIdle) ? active_oh : '0;
    fetch_req_o   = (phase_q == StFetch);
    lsu_req_o     = (phase_q == StWait) && mem_q;
    active_warp_o = active_q;
    busy_o        = busy_q;
    done_o        = done_q;
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: drives instruction streams per warp, records the issue
// order and handshake activity, and compares against expectations queued by each test.
module tb_warp_scheduler;

  localparam logic [2:0] W_IDLE = 3'd0, W_FETCH = 3'd1, W_DECODE = 3'd2, W_DONE = 3'd7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      num_warps = '0;
  logic            fetch_req, fetch_ack = 1'b0;
  logic            decoded_mem = 1'b0, decoded_ret = 1'b0;
  logic            lsu_req, lsu_done = 1'b0;
  logic [1:0]      active_warp;
  logic [3:0][2:0] warp_state;
  logic [3:0]      warp_enable;
  logic            busy, done;

  int total = 0;
  int bad = 0;

  warp_scheduler #(.NUM_WARPS(4), .WARP_IDX_W(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .num_warps_i  (num_warps),
    .fetch_req_o  (fetch_req),
    .fetch_ack_i  (fetch_ack),
    .decoded_mem_i(decoded_mem),
    .decoded_ret_i(decoded_ret),
    .lsu_req_o    (lsu_req),
    .lsu_done_i   (lsu_done),
    .active_warp_o(active_warp),
    .warp_state_o (warp_state),
    .warp_enable_o(warp_enable),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Per-run configuration.
  int n_launch, lsu_delay, fetch_wait, max_cycles, want_dones;
  int ret_at[4];
  bit mem_first[4];
  bit stray_en, restart_on_done;

  // Per-run observations and expectations.
  int obs_issue[$], obs_cyc[$], trace0[$], done_cycles[$];
  int exp_q[$];
  int issue_cnt, lsu_cnt, fetch_cnt, busy_cnt, proto_err, w1_regress;
  bit timed_out;

  task automatic configure(input int n);
    n_launch = n; lsu_delay = 1; fetch_wait = 0; max_cycles = 300; want_dones = 1;
    stray_en = 0; restart_on_done = 0;
    for (int i = 0; i < 4; i++) begin ret_at[i] = 0; mem_first[i] = 0; end
  endtask

  // Launch, then answer handshakes cycle by cycle at negedge, recording what the DUT does.
  task automatic run_launch();
    int cyc = 0, cur_k = 0, lcnt = 0, fcnt = 0;
    int icnt[4];
    logic [2:0] ast, prev_ast = W_IDLE;
    logic [1:0] act;
    bit w1_done_seen = 0;
    for (int i = 0; i < 4; i++) icnt[i] = 0;
    obs_issue.delete(); obs_cyc.delete(); trace0.delete(); done_cycles.delete();
    issue_cnt = 0; lsu_cnt = 0; fetch_cnt = 0; busy_cnt = 0; proto_err = 0; w1_regress = 0;
    timed_out = 0;
    @(negedge clk); start = 1'b1; num_warps = n_launch[2:0];
    @(negedge clk); start = 1'b0;
    forever begin
      cyc++;
      act = active_warp;
      ast = warp_state[act];
      trace0.push_back(int'(warp_state[0]));
      if (busy) busy_cnt++;
      if (warp_enable != 0) issue_cnt++;
      if (lsu_req) lsu_cnt++;
      if (fetch_req) fetch_cnt++;
      if (warp_enable != 0 && (warp_enable != (4'b1 << act) || ast == W_IDLE || ast == W_DONE))
        proto_err++;
      if (fetch_req != (warp_enable != 0 && ast == W_FETCH)) proto_err++;
      if (warp_enable != 0 && ast == W_FETCH && prev_ast != W_FETCH) begin
        obs_issue.push_back(int'(act)); obs_cyc.push_back(cyc);
        cur_k = icnt[act]; icnt[act]++; fcnt = 0;
      end
      prev_ast = (warp_enable != 0) ? ast : W_IDLE;
      if (w1_done_seen && warp_state[1] != W_DONE) w1_regress++;
      if (warp_state[1] == W_DONE) w1_done_seen = 1;
      if (done) done_cycles.push_back(cyc);
      // Inputs for the coming posedge.
      start = 1'b0;
      fetch_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      decoded_mem = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      decoded_ret = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      lsu_done    = (stray_en && !lsu_req) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (warp_enable != 0 && ast == W_FETCH) begin
        fetch_ack = (fcnt >= fetch_wait); fcnt++;
      end
      if (warp_enable != 0 && ast == W_DECODE) begin
        decoded_mem = mem_first[act] && cur_k == 0;
        decoded_ret = (cur_k == ret_at[act]);
      end
      if (lsu_req) begin lcnt++; lsu_done = (lcnt >= lsu_delay); end
      else lcnt = 0;
      if (stray_en && busy) begin
        start = 1'($urandom_range(0, 1)); num_warps = 3'($urandom_range(0, 7));
      end
      if (done && restart_on_done && done_cycles.size() == 1) begin
        start = 1'b1; num_warps = n_launch[2:0];
        for (int i = 0; i < 4; i++) icnt[i] = 0;
      end
      if (done_cycles.size() >= want_dones && cyc >= done_cycles[$] + 2) break;
      if (cyc >= max_cycles) begin timed_out = 1; break; end
      @(negedge clk);
    end
    start = 1'b0; fetch_ack = 1'b0; decoded_mem = 1'b0; decoded_ret = 1'b0; lsu_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2 rst_n = 1'b0; #5;
    total++; if (warp_state !== '0) begin bad++; $display("FAIL rst_state got %h want 0", warp_state); end
    total++; if (warp_enable !== 4'b0) begin bad++; $display("FAIL rst_enable got %b want 0", warp_enable); end
    total++; if ({fetch_req, lsu_req, busy, done} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got %b want 0000", {fetch_req, lsu_req, busy, done}); end
    total++; if (active_warp !== 2'd0) begin bad++; $display("FAIL rst_active got %0d want 0", active_warp); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    int e, o;
    configure(1);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 7};
    run_launch();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (trace0.size() > 0) ? trace0.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL t1_trace got %0d want %0d", o, e); end
    end
    total++; if (done_cycles.size() != 1 || done_cycles[0] != 7) begin
      bad++; $display("FAIL t1_done count=%0d first=%0d want 1 at 7", done_cycles.size(),
                      done_cycles.size() > 0 ? done_cycles[0] : -1); end
    total++; if (busy_cnt != 6) begin bad++; $display("FAIL t1_busy got %0d want 6", busy_cnt); end
  endtask

  task automatic test_round_robin();
    int e, o;
    configure(4);
    for (int i = 0; i < 4; i++) ret_at[i] = 2;
    for (int r = 0; r < 3; r++) for (int w = 0; w < 4; w++) exp_q.push_back(w);
    run_launch();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_issue.size() > 0) ? obs_issue.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL t2_order got %0d want %0d", o, e); end
    end
    total++; if (issue_cnt != 72) begin bad++; $display("FAIL t2_issue got %0d want 72", issue_cnt); end
    total++; if (done_cycles.size() != 1 || done_cycles[0] != 73) begin
      bad++; $display("FAIL t2_done count=%0d want 1 at 73", done_cycles.size()); end
    total++; if (proto_err != 0 || timed_out) begin
      bad++; $display("FAIL t2_proto errs=%0d timeout=%0d want 0", proto_err, timed_out); end
  endtask

  task automatic test_lsu();
    int e, o;
    configure(2);
    mem_first[0] = 1; lsu_delay = 5;
    exp_q = '{0, 1};
    run_launch();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_issue.size() > 0) ? obs_issue.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL t3_order got %0d want %0d", o, e); end
    end
    total++; if (lsu_cnt != 5) begin bad++; $display("FAIL t3_lsu_req got %0d want 5", lsu_cnt); end
    total++; if (obs_cyc.size() != 2 || obs_cyc[1] != 11) begin
      bad++; $display("FAIL t3_w1_issue got %0d want 11", obs_cyc.size() > 1 ? obs_cyc[1] : -1); end
    total++; if (done_cycles.size() != 1 || done_cycles[0] != 17) begin
      bad++; $display("FAIL t3_done count=%0d want 1 at 17", done_cycles.size()); end
  endtask

  task automatic test_early_ret();
    int e, o;
    configure(3);
    ret_at[0] = 2; ret_at[1] = 0; ret_at[2] = 2;
    exp_q = '{0, 1, 2, 0, 2, 0, 2};
    run_launch();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_issue.size() > 0) ? obs_issue.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL t4_order got %0d want %0d", o, e); end
    end
    total++; if (w1_regress != 0) begin bad++; $display("FAIL t4_w1_hold got %0d want 0", w1_regress); end
    total++; if (warp_state !== {W_IDLE, W_DONE, W_DONE, W_DONE}) begin
      bad++; $display("FAIL t4_final got %h want %h", warp_state, {W_IDLE, W_DONE, W_DONE, W_DONE}); end
    total++; if (done_cycles.size() != 1 || done_cycles[0] != 43) begin
      bad++; $display("FAIL t4_done count=%0d want 1 at 43", done_cycles.size()); end
  endtask

  task automatic test_zero();
    configure(0);
    max_cycles = 10;
    run_launch();
    total++; if (done_cycles.size() != 1 || done_cycles[0] != 1) begin
      bad++; $display("FAIL t5_done count=%0d want 1 at 1", done_cycles.size()); end
    total++; if (busy_cnt != 0 || obs_issue.size() != 0) begin
      bad++; $display("FAIL t5_busy busy=%0d issues=%0d want 0 0", busy_cnt, obs_issue.size()); end
  endtask

  task automatic test_clamp_reset();
    int e, o;
    configure(7);
    exp_q = '{0, 1, 2, 3};
    run_launch();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_issue.size() > 0) ? obs_issue.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL t6_clamp got %0d want %0d", o, e); end
    end
    total++; if (obs_issue.size() != 0 || done_cycles.size() != 1 || done_cycles[0] != 25) begin
      bad++; $display("FAIL t6_clamp_done extra=%0d dones=%0d want 0 1", obs_issue.size(),
                      done_cycles.size()); end
    // Stall warp 1 in WAIT, then reset asynchronously between clock edges.
    configure(2);
    mem_first[1] = 1; lsu_delay = 1000; max_cycles = 12;
    run_launch();
    total++; if (lsu_req !== 1'b1 || active_warp !== 2'd1) begin
      bad++; $display("FAIL t6_stall lsu_req=%b active=%0d want 1 1", lsu_req, active_warp); end
    #2 rst_n = 1'b0; #1;
    total++; if ({lsu_req, fetch_req, busy, done} !== 4'b0 || warp_enable !== 4'b0) begin
      bad++; $display("FAIL t6_rst_flags got %b/%b want 0", {lsu_req, fetch_req, busy, done},
                      warp_enable); end
    total++; if (warp_state !== '0 || active_warp !== 2'd0) begin
      bad++; $display("FAIL t6_rst_state got %h/%0d want 0/0", warp_state, active_warp); end
    @(negedge clk); rst_n = 1'b1; lsu_done = 1'b1; fetch_ack = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({lsu_req, fetch_req, busy} !== 3'b0) begin
      bad++; $display("FAIL t6_no_resume got %b want 000", {lsu_req, fetch_req, busy}); end
    lsu_done = 1'b0; fetch_ack = 1'b0;
  endtask

  task automatic test_stray();
    int e, o;
    configure(2);
    ret_at[0] = 1; ret_at[1] = 1; fetch_wait = 2; stray_en = 1;
    exp_q = '{0, 1, 0, 1};
    run_launch();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_issue.size() > 0) ? obs_issue.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL t7_order got %0d want %0d", o, e); end
    end
    total++; if (fetch_cnt != 12 || issue_cnt != 32) begin
      bad++; $display("FAIL t7_cycles fetch=%0d issue=%0d want 12 32", fetch_cnt, issue_cnt); end
    total++; if (done_cycles.size() != 1 || done_cycles[0] != 33 || proto_err != 0) begin
      bad++; $display("FAIL t7_done count=%0d errs=%0d want 1 at 33, 0", done_cycles.size(),
                      proto_err); end
  endtask

  task automatic test_back_to_back();
    configure(1);
    restart_on_done = 1; want_dones = 2;
    exp_q = '{1, 8, 7, 14};
    run_launch();
    total++; if (obs_cyc.size() != 2 || obs_cyc[0] != exp_q[0] || obs_cyc[1] != exp_q[1]) begin
      bad++; $display("FAIL b2b_issue got n=%0d want cycles 1,8", obs_cyc.size()); end
    total++; if (done_cycles.size() != 2 || done_cycles[0] != exp_q[2] || done_cycles[1] != exp_q[3]) begin
      bad++; $display("FAIL b2b_done got n=%0d want cycles 7,14", done_cycles.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lsu();
    test_early_ret();
    test_zero();
    test_clamp_reset();
    test_stray();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
